// File: rtl/ter_pkg.sv
// Shared ternary types, scheduler states and the Z3 arithmetic helpers.
// Every mod-3 operation in the design goes through mul_ter and add_ter.
package ter_pkg;

  typedef logic [1:0] ter_t;

  localparam ter_t TER_ZERO = 2'b00;
  localparam ter_t TER_POS  = 2'b01;
  localparam ter_t TER_NEG  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} sched_state_t;

  // The unused code 2'b10 reads as zero.
  function automatic logic signed [2:0] ter_val(input ter_t t);
    if (t == TER_POS)      return 3'sd1;
    else if (t == TER_NEG) return -3'sd1;
    else                   return 3'sd0;
  endfunction

  function automatic ter_t mul_ter(input ter_t x, input ter_t y);
    if ((ter_val(x) == 3'sd0) || (ter_val(y) == 3'sd0)) return TER_ZERO;
    else if (x == y)                                    return TER_POS;
    else                                                return TER_NEG;
  endfunction

  function automatic ter_t add_ter(input ter_t x, input ter_t y);
    logic signed [2:0] s;
    s = ter_val(x) + ter_val(y);
    if ((s == 3'sd2) || (s == -3'sd1))      return TER_NEG;
    else if ((s == -3'sd2) || (s == 3'sd1)) return TER_POS;
    else                                    return TER_ZERO;
  endfunction

endpackage

// File: rtl/ter_mac_acc.sv
// Serial ternary multiply-accumulate: one product per valid cycle, restart on
// the first marker, present the completed sum combinationally on the last marker.
module ter_mac_acc
  import ter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic first,
  input  logic last,
  input  ter_t x,
  input  ter_t y,
  output logic res_vld,
  output ter_t res
);

  ter_t acc_q, acc_d;
  ter_t prod;
  ter_t sum;

  always_comb begin
    prod    = mul_ter(x, y);
    sum     = first ? prod : add_ter(acc_q, prod);
    acc_d   = vld ? sum : acc_q;
    res_vld = vld & last;
    res     = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= TER_ZERO;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/ter_conv_sched.sv
// Sequencer for one serial ternary MAC lane computing c = a*b mod (x^N - 1) over Z3.
// Issues (i, j=(k-i) mod N) read pairs, k outer and i inner, and streams c[k] out.
module ter_conv_sched
  import ter_pkg::*;
#(
  parameter int N  = 701,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  input  ter_t          a_rdata,
  output logic [AW-1:0] b_addr,
  input  ter_t          b_rdata,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output ter_t          c_wdata,
  output sched_state_t  dbg_state
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  sched_state_t  state_q, state_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic          vld_q, vld_d, first_q, first_d, last_q, last_d;
  logic [AW-1:0] kp_q, kp_d;
  logic          c_we_q, c_we_d;
  logic [AW-1:0] c_addr_q, c_addr_d;
  ter_t          c_wdata_q, c_wdata_d;
  logic          res_vld;
  ter_t          res;

  ter_mac_acc u_mac (
    .clk     (clk),
    .rst     (rst),
    .vld     (vld_q),
    .first   (first_q),
    .last    (last_q),
    .x       (a_rdata),
    .y       (b_rdata),
    .res_vld (res_vld),
    .res     (res)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    // Markers ride one stage beside the RAM read so they line up with rdata.
    vld_d     = (state_q == RUN);
    first_d   = (i_q == '0);
    last_d    = (i_q == LAST);
    kp_d      = k_q;
    c_we_d    = res_vld;
    c_addr_d  = res_vld ? kp_q : c_addr_q;
    c_wdata_d = res_vld ? res : c_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if ((i_q == LAST) && (k_q == LAST)) begin
          state_d = FLUSH;
        end else if (i_q == LAST) begin
          i_d = '0;
          j_d = k_q + 1'b1;
          k_d = k_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
          j_d = (j_q == '0) ? LAST : j_q - 1'b1;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      kp_q      <= '0;
      c_we_q    <= 1'b0;
      c_addr_q  <= '0;
      c_wdata_q <= TER_ZERO;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      vld_q     <= vld_d;
      first_q   <= first_d;
      last_q    <= last_d;
      kp_q      <= kp_d;
      c_we_q    <= c_we_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == FLUSH);
  assign done      = (state_q == DONE);
  assign a_addr    = i_q;
  assign b_addr    = j_q;
  assign c_we      = c_we_q;
  assign c_addr    = c_addr_q;
  assign c_wdata   = c_wdata_q;
  assign dbg_state = state_q;

endmodule
